vedic_mult8_pipe: RTL and testbench

VEDIC_MULT8_PIPE -- requirements
Module: vedic_mult8_pipe

---
 rtl/vedic_mult8_pipe.sv | 104 ++++++++++
 tb/tb_vedic_mult8_pipe.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vedic_mult8_pipe.sv
// 8x8 unsigned multiplier built from 4x4 Vedic (Urdhva-Tiryagbhyam) blocks, three-stage valid/ready pipeline.
// Optional completed-product counter on done_cnt when VEDIC_PERF_CNT_EN is defined.
module vedic_mult8_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] prod,
  output logic        out_valid,
  input  logic        out_ready
`ifdef VEDIC_PERF_CNT_EN
  ,
  output logic [15:0] done_cnt
`endif
);

  function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
    logic       w_c;
    logic [3:0] w_r;
    w_r[0]        = x[0] & y[0];
    {w_c, w_r[1]} = {1'b0, x[1] & y[0]} + {1'b0, x[0] & y[1]};
    w_r[2]        = (x[1] & y[1]) ^ w_c;
    w_r[3]        = (x[1] & y[1]) & w_c;
    return w_r;
  endfunction

  function automatic logic [7:0] vedic4x4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] w_q0, w_q1, w_q2, w_q3;
    logic [4:0] w_t1;
    logic [5:0] w_t2;
    w_q0 = vedic2x2(x[1:0], y[1:0]);
    w_q1 = vedic2x2(x[3:2], y[1:0]);
    w_q2 = vedic2x2(x[1:0], y[3:2]);
    w_q3 = vedic2x2(x[3:2], y[3:2]);
    w_t1 = {1'b0, w_q1} + {1'b0, w_q2};
    w_t2 = {w_q3, w_q0[3:2]} + {1'b0, w_t1};
    return {w_t2, w_q0[1:0]};
  endfunction

  logic        r_v1, r_v2, r_v3;
  logic [7:0]  r_p0, r_p1, r_p2, r_p3;
  logic [8:0]  r_s1;
  logic [7:0]  r_p3_s2, r_p0_s2;
  logic [15:0] r_prod;
  logic        w_adv1, w_adv2, w_adv3;
  logic [11:0] w_s2;

  assign w_adv3    = !r_v3 || out_ready;
  assign w_adv2    = !r_v2 || w_adv3;
  assign w_adv1    = !r_v1 || w_adv2;
  assign in_ready  = w_adv1;
  assign out_valid = r_v3;
  assign prod      = r_prod;

  // Carry out of s2 cannot occur (max 3614 + 450 = 4064), so 12 bits are exact.
  assign w_s2 = {r_p3_s2, r_p0_s2[7:4]} + {3'b000, r_s1};

  // Datapath registers: load only when their stage advances with a valid predecessor.
  always_ff @(posedge clk) begin
    if (w_adv1 && in_valid) begin
      r_p0 <= vedic4x4(a[3:0], b[3:0]);
      r_p1 <= vedic4x4(a[7:4], b[3:0]);
      r_p2 <= vedic4x4(a[3:0], b[7:4]);
      r_p3 <= vedic4x4(a[7:4], b[7:4]);
    end
    if (w_adv2 && r_v1) begin
      r_s1    <= {1'b0, r_p1} + {1'b0, r_p2};
      r_p3_s2 <= r_p3;
      r_p0_s2 <= r_p0;
    end
  end

  // Stage valid bits and the output register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_prod <= 16'h0000;
    end else begin
      if (w_adv1) r_v1 <= in_valid;
      if (w_adv2) r_v2 <= r_v1;
      if (w_adv3) r_v3 <= r_v2;
      if (w_adv3 && r_v2) r_prod <= {w_s2, r_p0_s2[3:0]};
    end
  end

`ifdef VEDIC_PERF_CNT_EN
  logic [15:0] r_done_cnt;
  assign done_cnt = r_done_cnt;

  // Counts output transfers, wrapping naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_done_cnt <= 16'h0000;
    end else if (r_v3 && out_ready) begin
      r_done_cnt <= r_done_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_vedic_mult8_pipe.sv
// Randomized self-checking bench for vedic_mult8_pipe; a queue of a*b products is the reference.
// Also exercises the done_cnt counter when VEDIC_PERF_CNT_EN is defined.
module tb_vedic_mult8_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  a = 8'h00, b = 8'h00;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [15:0] prod;
`ifdef VEDIC_PERF_CNT_EN
  logic [15:0] done_cnt;
`endif

  vedic_mult8_pipe dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .prod(prod), .out_valid(out_valid), .out_ready(out_ready)
`ifdef VEDIC_PERF_CNT_EN
    , .done_cnt(done_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0, n_errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cnt_model = 16'h0000;
  logic        last_acc, obs_ir, obs_ov;
  logic [15:0] obs_prod;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive at negedge, sample shortly after, update the reference model.
  task automatic cycle(input logic rstv, input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                       input logic ordy);
    logic [15:0] p;
    @(negedge clk);
    rst_n = rstv; in_valid = iv; a = ia; b = ib; out_ready = ordy;
    #1;
    obs_ir = in_ready; obs_ov = out_valid; obs_prod = prod;
    last_acc = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      cnt_model = 16'h0000;
    end else begin
      if (in_valid && in_ready) begin
        p = {8'h00, ia} * {8'h00, ib};
        exp_q.push_back(p);
        last_acc = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("spurious_out", 32'd1, 32'd0);
        else check_eq("prod", {16'h0000, prod}, {16'h0000, exp_q.pop_front()});
        cnt_model = cnt_model + 16'h0001;
      end
    end
    @(posedge clk);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
      n++;
    end
    check_eq("drain_empty", exp_q.size(), 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  ca[4], cb[4], sa[4], sb[4];
    logic [15:0] cexp[4];
    int          acc, guard, ghost;

    // Reset state
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    check_eq("rst_out_valid", obs_ov, 32'd0);
    check_eq("rst_in_ready", obs_ir, 32'd1);
    check_eq("rst_prod", obs_prod, 32'h0);
`ifdef VEDIC_PERF_CNT_EN
    check_eq("rst_done_cnt", done_cnt, 32'h0);
`endif

    // Single transaction, 3-cycle latency, one-cycle valid pulse
    cycle(1'b1, 1'b1, 8'h12, 8'h34, 1'b1);
    check_eq("single_acc", last_acc, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
      check_eq("single_ov", obs_ov, (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) check_eq("single_prod", obs_prod, 32'h03A8);
    end

    // Corner operands back to back
    ca = '{8'hFF, 8'h00, 8'hF0, 8'h01};
    cb = '{8'hFF, 8'hA5, 8'h0F, 8'hFF};
    cexp = '{16'hFE01, 16'h0000, 16'h0E10, 16'h00FF};
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, ca[i], cb[i], 1'b1);
    check_eq("corner_ov0", obs_ov, 32'd1);
    check_eq("corner_p0", obs_prod, {16'h0, cexp[0]});
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
      check_eq("corner_ov", obs_ov, (k < 3) ? 32'd1 : 32'd0);
      if (k < 3) check_eq("corner_p", obs_prod, {16'h0, cexp[k+1]});
    end
    drain(10);

    // Stall: three accepted, fourth refused, output held
    sa = '{8'h11, 8'h33, 8'h55, 8'h77};
    sb = '{8'h22, 8'h44, 8'h66, 8'h88};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, sa[i], sb[i], 1'b0);
      check_eq("stall_acc", last_acc, 32'd1);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, sa[3], sb[3], 1'b0);
      check_eq("stall_in_ready", obs_ir, 32'd0);
      check_eq("stall_ov", obs_ov, 32'd1);
      check_eq("stall_prod_hold", obs_prod, 32'h0242);
    end
    guard = 0;
    do begin
      cycle(1'b1, 1'b1, sa[3], sb[3], 1'b1);
      guard++;
    end while (!last_acc && guard < 5);
    check_eq("stall_fourth_acc", last_acc, 32'd1);
    drain(20);

    // Random traffic with random stalls
    acc = 0; guard = 0;
    while (acc < 1000 && guard < 20000) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      if (last_acc) acc++;
      guard++;
    end
    check_eq("rand_accepted", acc, 32'd1000);
    drain(50);

    // Reset mid-flight discards in-flight products
    cycle(1'b1, 1'b1, 8'h21, 8'h43, 1'b0);
    cycle(1'b1, 1'b1, 8'h65, 8'h87, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    ghost = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
      if (k == 0) begin
        check_eq("mid_rst_ov", obs_ov, 32'd0);
        check_eq("mid_rst_in_ready", obs_ir, 32'd1);
`ifdef VEDIC_PERF_CNT_EN
        check_eq("mid_rst_done_cnt", done_cnt, 32'h0);
`endif
      end
      if (obs_ov) ghost++;
    end
    check_eq("mid_rst_no_ghost", ghost, 32'd0);

`ifdef VEDIC_PERF_CNT_EN
    // Counter wrap after 65537 transfers
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 65537; i++) cycle(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
    drain(10);
    check_eq("cnt_model", cnt_model, 32'h0001);
    check_eq("cnt_wrap", done_cnt, {16'h0, cnt_model});
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
